// File: rtl/debouncer_bank.sv
// debouncer_bank: per-channel synchroniser + lockout or integrate filter with level, rise/fall strobes, busy.
// Latency SYNC_STAGES+1 edges (lockout) or SYNC_STAGES+CLK_WAIT edges (integrate); no backpressure, outputs free-running.

module debounce_chan #(
   parameter int CLK_WAIT    = 25000000,
   parameter int SYNC_STAGES = 2,
   parameter int MODE        = 0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic button,
   output logic signal,
   output logic rise,
   output logic fall,
   output logic busy
);
   localparam int CW = $clog2(CLK_WAIT + 1);
   localparam logic [CW-1:0] LAST = CW'(CLK_WAIT - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_INTEG} state_t;

   logic [SYNC_STAGES-1:0] sync_sh;
   logic                   sync;
   state_t                 state, state_nxt;
   logic [CW-1:0]          count, count_nxt;
   logic                   signal_nxt, rise_nxt, fall_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) sync_sh <= '0;
      else          sync_sh <= {sync_sh[SYNC_STAGES-2:0], button};
   end

   assign sync = sync_sh[SYNC_STAGES-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= ST_IDLE;
         count  <= '0;
         signal <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         signal <= signal_nxt;
         rise   <= rise_nxt;
         fall   <= fall_nxt;
         busy   <= (state_nxt != ST_IDLE);
      end
   end

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      signal_nxt = signal;
      rise_nxt   = 1'b0;
      fall_nxt   = 1'b0;
      if (MODE == 0) begin
         // Follow the first change at once, then ignore the input for CLK_WAIT cycles.
         case (state)
            ST_LOCK: begin
               if (count == LAST) begin
                  state_nxt = ST_IDLE;
                  count_nxt = '0;
               end else begin
                  count_nxt = count + ONE;
               end
            end
            default: begin
               if (sync != signal) begin
                  signal_nxt = sync;
                  count_nxt  = '0;
                  state_nxt  = ST_LOCK;
                  rise_nxt   = sync;
                  fall_nxt   = ~sync;
               end
            end
         endcase
      end else begin
         // Any sample that agrees with the output restarts the integration.
         if (sync == signal) begin
            count_nxt = '0;
         end else if (count == LAST) begin
            signal_nxt = sync;
            count_nxt  = '0;
            rise_nxt   = sync;
            fall_nxt   = ~sync;
         end else begin
            count_nxt = count + ONE;
         end
         state_nxt = (count_nxt != '0) ? ST_INTEG : ST_IDLE;
      end
   end
endmodule

module debouncer_bank #(
   parameter int CHANNELS    = 4,
   parameter int CLK_WAIT    = 25000000,
   parameter int SYNC_STAGES = 2,
   parameter int MODE        = 0
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [CHANNELS-1:0] button,
   output logic [CHANNELS-1:0] signal,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] busy
);
   for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
      debounce_chan #(
         .CLK_WAIT   (CLK_WAIT),
         .SYNC_STAGES(SYNC_STAGES),
         .MODE       (MODE)
      ) u_chan (
         .i_clk  (i_clk),
         .i_rst_n(i_rst_n),
         .button (button[n]),
         .signal (signal[n]),
         .rise   (rise[n]),
         .fall   (fall[n]),
         .busy   (busy[n])
      );
   end
endmodule

// File: doc/debouncer_bank.md
Name: debouncer_bank

Overview:
- Multi-channel, parametrised debouncer for front-panel buttons and slow trigger inputs ahead of the capture/control logic.
- Each channel has:
  - its own input synchroniser;
  - its own timing counter;
  - a choice of two filtering modes: immediate-follow-then-lockout, or stable-integration.
- Each channel emits its debounced level, single-cycle rise/fall strobes, and a busy flag, so downstream FSMs need no edge detectors of their own.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- CLK_WAIT, 25000000: lockout or integration length in i_clk cycles (>=2).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- MODE, 0: filtering mode, applied to all channels.
  - 0 = lockout: output follows the first change immediately, then ignores the input for CLK_WAIT cycles.
  - 1 = integrate: input must differ from the output for CLK_WAIT consecutive samples before the output changes.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- button  input  CHANNELS  raw asynchronous inputs; bit n belongs to channel n.
- signal  output  CHANNELS  debounced levels (registered).
- rise  output  CHANNELS  one-cycle pulse when signal[n] goes 0->1 (registered).
- fall  output  CHANNELS  one-cycle pulse when signal[n] goes 1->0 (registered).
- busy  output  CHANNELS  channel is in lockout (MODE 0) or has a change pending (MODE 1) (registered).

Behaviour:
- Reset (i_rst_n low, asynchronous, any time including mid-lockout or mid-integration):
  - all synchroniser flops = 0;
  - all counters = 0;
  - signal = 0, rise = 0, fall = 0, busy = 0.
  - Release is synchronous to the next i_clk edge.
- Synchroniser: button[n] passes through SYNC_STAGES flops; "sync[n]" is the last stage. The logic below uses sync[n] only.
- Counter: one per channel, width $clog2(CLK_WAIT+1), unsigned. It never wraps; it is always cleared before reaching CLK_WAIT.
- Channels are fully independent. Simultaneous events on different channels are processed in the same cycle without interaction.
- Strobes:
  - rise[n] and fall[n] are high for exactly the one cycle after the edge that updates signal[n]; otherwise 0.
  - rise[n] and fall[n] are never high together.
- MODE 0, lockout, per channel:
  - IDLE (busy=0): if sync != signal at edge T:
    - signal <= sync, count <= 0, busy <= 1, strobe fires;
    - otherwise nothing changes.
  - LOCK (busy=1): every edge, count <= count+1 and input changes are ignored. At the edge where count == CLK_WAIT-1: busy <= 0, count <= 0.
  - Timing: busy is high for exactly CLK_WAIT cycles (edges T..T+CLK_WAIT-1). The earliest next accepted change is at edge T+CLK_WAIT+1.
  - If sync differs from signal when lockout ends, it is accepted at that next edge. Level mismatches are never lost.
  - Latency from a clean button change to signal = SYNC_STAGES+1 edges.
- MODE 1, integrate, per channel:
  - If sync == signal: count <= 0.
  - Else if count == CLK_WAIT-1: signal <= sync, count <= 0, strobe fires.
  - Else: count <= count+1.
  - busy = (count != 0), registered together with count.
  - A single sample of sync == signal restarts the integration.
  - Latency for a clean change = SYNC_STAGES+CLK_WAIT edges.
  - A glitch shorter than CLK_WAIT cycles never reaches signal.
- No other outputs; no combinational paths from button to any output.

Test Plan (CLK_WAIT=8, SYNC_STAGES=2, CHANNELS=4 unless stated):
- Reset mid-operation:
  - Stimulus: MODE 0; ch0 0->1, then assert i_rst_n low during lockout cycle 3.
  - Required: signal, busy, rise and fall go to 0 asynchronously, before the next edge. After release with button[0]=1, ch0 re-accepts: signal[0]=1 and rise[0] pulses 3 edges after release.
- Lockout timing and strobes:
  - Stimulus: MODE 0; button[1] 0->1 at edge 0.
  - Required: signal[1]=1 and rise[1] high for one cycle after edge 3; busy[1] high for exactly 8 cycles.
  - Stimulus: button[1]->0 during lockout.
  - Required: ignored until lockout ends, then signal[1]=0 with a fall[1] pulse.
- Bounce suppression:
  - Stimulus: MODE 0; ch2 toggles every cycle for 6 cycles, ending at 1.
  - Required: exactly one rise[2] and no fall[2]; final signal[2]=1.
- Integration:
  - Stimulus: MODE 1; ch3 held high 7 cycles, one low sample, then held high.
  - Required: no change during the 7-cycle hold, and busy[3] returns to 0 at the low sample. signal[3] rises 8 edges after the final rising sync sample; one rise[3] pulse.
- Channel independence:
  - Stimulus: MODE 0; all 4 buttons change on the same edge, with different polarities.
  - Required: all signals update on the same edge, with correct rise/fall per bit, and lockouts expire together.
- Parameter sweep:
  - Stimulus: CHANNELS=1, CLK_WAIT=2, SYNC_STAGES=3.
  - Required: busy width exactly 2 cycles; latency 4 edges (MODE 0) and 5 edges (MODE 1).
